// File: rtl/mdio_controller_pkg.sv
// Shared definitions for the Clause-22 MDIO management master:
// state encoding, opcodes, frame field positions and widths.
package mdio_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SEND,
        ST_TURNAROUND,
        ST_RECEIVE
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Frame layout: {ST, OP, PHYAD, REGAD, TA, DATA}
    localparam int ST_HI    = 31;
    localparam int OP_HI    = 29;
    localparam int OP_LO    = 28;
    localparam int PHYAD_HI = 27;
    localparam int REGAD_HI = 22;
    localparam int TA_HI    = 17;

    localparam int FRAME_W  = 32;
    localparam int ADDR_W   = 14;
    localparam int TA_W     = 2;
    localparam int DATA_W   = 16;
    localparam int PRE_W    = 32;

    // Counter value on the final bit of a field of width w.
    function automatic logic [4:0] last_bit(input int w);
        return 5'(w - 1);
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: low half then high half per bit period, with
// strobes on the cycle before MDC rises and on the last bit cycle.
module mdio_clkgen #(
    parameter int MDC_HALF = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_o,
    output logic bit_end_o
);

    localparam int CW = (MDC_HALF > 1) ? $clog2(2 * MDC_HALF) : 1;
    localparam logic [CW-1:0] HALF = CW'(MDC_HALF);
    localparam logic [CW-1:0] RISE = CW'(MDC_HALF - 1);
    localparam logic [CW-1:0] LAST = CW'(2 * MDC_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Phase within the bit period; parked at 0 while disabled.
    always_comb begin
        cnt_d = '0;
        if (en_i && cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdc_o     = en_i && (cnt_q >= HALF);
    assign rise_o    = en_i && (cnt_q == RISE);
    assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mdio_controller.sv
// Clause-22 MDIO master: shifts a 32-bit frame out, captures read data.
// Optional 32-bit all-ones preamble when MDIO_PREAMBLE_EN is defined.
module mdio_controller
    import mdio_controller_pkg::*;
#(
    parameter int MDC_HALF = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT
);

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] rd_q, rd_d;
    logic        rdy_q, rdy_d;
    logic        read_q, read_d;
    logic        oe, out_bit;
    logic        mdc, rise, bit_end;

    mdio_clkgen #(
        .MDC_HALF (MDC_HALF)
    ) u_clkgen (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .en_i      (state_q != ST_IDLE),
        .mdc_o     (mdc),
        .rise_o    (rise),
        .bit_end_o (bit_end)
    );

    // Frame sequencing, shift register and read-data capture.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        rdy_d   = rdy_q;
        read_d  = read_q;
        oe      = 1'b0;
        out_bit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (MDIO_START) begin
                    sr_d   = T_DATA;
                    read_d = (T_DATA[OP_HI:OP_LO] == OP_READ);
                    rdy_d  = 1'b0;
                    bit_d  = '0;
`ifdef MDIO_PREAMBLE_EN
                    state_d = ST_PREAMBLE;
`else
                    state_d = ST_SEND;
`endif
                end
            end
            ST_PREAMBLE: begin
                oe      = 1'b1;
                out_bit = 1'b1;
                if (bit_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == last_bit(PRE_W)) begin
                        bit_d   = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                oe      = 1'b1;
                out_bit = sr_q[FRAME_W-1];
                if (bit_end) begin
                    sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
                    bit_d = bit_q + 5'd1;
                    if (read_q && bit_q == last_bit(ADDR_W)) begin
                        bit_d   = '0;
                        state_d = ST_TURNAROUND;
                    end else if (bit_q == last_bit(FRAME_W)) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TURNAROUND: begin
                if (bit_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == last_bit(TA_W)) begin
                        bit_d   = '0;
                        state_d = ST_RECEIVE;
                    end
                end
            end
            ST_RECEIVE: begin
                if (rise) begin
                    rd_d = {rd_q[DATA_W-2:0], MDIO_IN};
                end
                if (bit_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == last_bit(DATA_W)) begin
                        bit_d   = '0;
                        rdy_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            rd_q    <= '0;
            rdy_q   <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            read_q  <= read_d;
        end
    end

    assign MDC      = mdc;
    assign MDIO_OE  = oe;
    assign MDIO_OUT = oe & out_bit;
    assign RD_DATA  = rd_q;
    assign DATA_RDY = rdy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller (default MDC_HALF = 1).
// Honours MDIO_PREAMBLE_EN when the design is built with it.
module tb_mdio_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;

`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
    localparam int WR_OE_CYC = 128;
    localparam int RD_OE_CYC = 92;
`else
    localparam int PRE = 0;
    localparam int WR_OE_CYC = 64;
    localparam int RD_OE_CYC = 28;
`endif

    mdio_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY),
        .MDC        (MDC),
        .MDIO_OE    (MDIO_OE),
        .MDIO_OUT   (MDIO_OUT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic        e_mdc, e_oe, e_out, e_rdy;
    logic [15:0] e_rd;
    int          oe_cyc;
    logic [31:0] cap;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle outside reset, the DUT must match the model.
    always @(negedge CLK) begin
        if (chk_en && !RESET) begin
            chk("mdc",      32'(MDC),      32'(e_mdc));
            chk("mdio_oe",  32'(MDIO_OE),  32'(e_oe));
            chk("mdio_out", 32'(MDIO_OUT), 32'(e_out));
            chk("data_rdy", 32'(DATA_RDY), 32'(e_rdy));
            chk("rd_data",  32'(RD_DATA),  32'(e_rd));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_mdc"},  32'(MDC),      32'd0);
        chk({pfx, "_oe"},   32'(MDIO_OE),  32'd0);
        chk({pfx, "_out"},  32'(MDIO_OUT), 32'd0);
        chk({pfx, "_rdy"},  32'(DATA_RDY), 32'd0);
        chk({pfx, "_rd"},   32'(RD_DATA),  32'd0);
    endtask

    // Issue one frame and walk the model through it bit by bit.
    task automatic run_frame(input logic [31:0] t, input logic [15:0] phy,
                             input bit hold, input bit poke, input bit abort);
        bit rd;
        int nb, b, fb;
        bit h;
        rd     = (t[29:28] == 2'b10);
        nb     = PRE + 32;
        oe_cyc = 0;
        cap    = '0;
        MDIO_START = 1'b1;
        T_DATA     = t;
        tick();
        if (!hold) MDIO_START = 1'b0;
        T_DATA = $urandom;
        e_rdy  = 1'b0;
        for (int k = 0; k < 2 * nb; k++) begin
            b  = k / 2;
            h  = (k % 2) == 1;
            fb = b - PRE;
            e_mdc = h;
            if (b < PRE) begin
                e_oe = 1'b1;
                e_out = 1'b1;
            end else if (!rd || fb < 14) begin
                e_oe = 1'b1;
                e_out = t[31-fb];
            end else begin
                e_oe = 1'b0;
                e_out = 1'b0;
            end
            if (rd && fb >= 16) begin
                MDIO_IN = phy[15-(fb-16)];
                if (h) e_rd = {e_rd[14:0], MDIO_IN};
            end else begin
                MDIO_IN = 1'($urandom);
            end
            if (poke && k == 20) begin
                MDIO_START = 1'b1;
                T_DATA = $urandom;
            end
            if (poke && k == 22) MDIO_START = hold;
            if (abort && rd && fb == 24 && !h) begin
                #1 RESET = 1'b1;
                #1;
                chk_zero("abort");
                e_mdc = 0; e_oe = 0; e_out = 0; e_rdy = 0; e_rd = '0;
                MDIO_START = 1'b0;
                tick();
                RESET = 1'b0;
                return;
            end
            #3;
            if (MDIO_OE) oe_cyc++;
            if (h) cap = {cap[30:0], MDIO_OUT};
            tick();
        end
        e_mdc = 1'b0;
        e_oe  = 1'b0;
        e_out = 1'b0;
        if (rd) e_rdy = 1'b1;
    endtask

    initial begin
        logic [31:0] t;
        bit hold, poke;
        RESET = 1'b1;
        MDIO_START = 1'b0;
        MDIO_IN = 1'b0;
        T_DATA = '0;
        e_mdc = 0; e_oe = 0; e_out = 0; e_rdy = 0; e_rd = '0;
        repeat (3) tick();
        chk_zero("reset");
        RESET = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();

        run_frame(32'h50883C33, 16'h0000, 0, 0, 0);
        chk("wr_oe_cycles", 32'(oe_cyc), 32'(WR_OE_CYC));
        chk("wr_serial", cap, 32'h50883C33);
        chk("wr_rdy", 32'(DATA_RDY), 32'd0);
        tick();

        run_frame(32'h61900000, 16'hA5A5, 0, 0, 0);
        chk("rd_oe_cycles", 32'(oe_cyc), 32'(RD_OE_CYC));
        chk("rd_data_lit", 32'(RD_DATA), 32'h0000A5A5);
        chk("rd_rdy_lit", 32'(DATA_RDY), 32'd1);
        repeat (5) tick();
        chk("rd_hold_lit", 32'(RD_DATA), 32'h0000A5A5);

        run_frame(32'h5A5C3C0F, 16'h0000, 0, 1, 0);
        chk("busy_serial", cap, 32'h5A5C3C0F);
        tick();

        run_frame(32'h61900000, 16'h1234, 0, 0, 1);
        chk("abort_rd_after", 32'(RD_DATA), 32'd0);
        chk("abort_rdy_after", 32'(DATA_RDY), 32'd0);
        tick();
        run_frame(32'h61900000, 16'h5AC3, 0, 0, 0);
        chk("post_abort_rd", 32'(RD_DATA), 32'h00005AC3);
        chk("post_abort_rdy", 32'(DATA_RDY), 32'd1);
        tick();

        run_frame(32'h50883C33, 16'h0000, 1, 0, 0);
        run_frame(32'h6A5C0000, 16'hC0DE, 1, 0, 0);
        run_frame(32'h50883C33, 16'h0000, 0, 0, 0);
        chk("hold_rd_kept", 32'(RD_DATA), 32'h0000C0DE);
        chk("hold_rdy_clr", 32'(DATA_RDY), 32'd0);

        for (int i = 0; i < 24; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 1) t[29:28] = 2'b10;
            hold = ($urandom_range(0, 3) == 0);
            poke = ($urandom_range(0, 2) == 0);
            run_frame(t, 16'($urandom), hold, poke, 0);
            if (!MDIO_START) repeat ($urandom_range(0, 3)) tick();
        end
        MDIO_START = 1'b0;
        repeat (4) tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
